// File: rtl/dec_mult_pkg.sv
// Shared definitions for the decimal multiple generator: digit width,
// sequencer state encoding, 4221 digit decode and the 4221->5211 recoder.
package dec_mult_pkg;

    localparam int DIG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DBL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Value of one 4221-coded digit; every 4-bit pattern maps into 0..9.
    function automatic logic [3:0] dec4221_val(input logic [3:0] d);
        return {1'b0, d[3], 2'b00} + {2'b00, d[2], 1'b0}
             + {2'b00, d[1], 1'b0} + {3'b000, d[0]};
    endfunction

    // 5211 code (weights 5,2,1,1) for a digit value 0..9.
    function automatic logic [3:0] recode_5211(input logic [3:0] v);
        logic [3:0] s;
        case (v)
            4'd0:    s = 4'b0000;
            4'd1:    s = 4'b0001;
            4'd2:    s = 4'b0011;
            4'd3:    s = 4'b0101;
            4'd4:    s = 4'b0111;
            4'd5:    s = 4'b1000;
            4'd6:    s = 4'b1001;
            4'd7:    s = 4'b1011;
            4'd8:    s = 4'b1101;
            4'd9:    s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Doubled digit: the low three 5211 bits shifted up, incoming carry in the LSB.
    function automatic logic [3:0] dbl_digit(input logic [3:0] d, input logic cin);
        return (recode_5211(dec4221_val(d)) << 1) | {3'b000, cin};
    endfunction

    // Carry leaving a digit when it is doubled: the weight-5 bit of its 5211 code.
    function automatic logic dbl_carry(input logic [3:0] d);
        return (recode_5211(dec4221_val(d)) > 4'd7);
    endfunction

endpackage

// File: rtl/dec_multiple_gen_ctrl_if.sv
// Operand load / multiple delivery bus of the decimal multiple generator.
interface dec_multiple_gen_ctrl_if #(parameter int N_DIG = 16);

    localparam int W_IN  = dec_mult_pkg::DIG_W * N_DIG;
    localparam int W_OUT = dec_mult_pkg::DIG_W * (N_DIG + 1);

    logic             start;
    logic [W_IN-1:0]  x_in;
    logic             busy;
    logic [W_OUT-1:0] m1_out;
    logic [W_OUT-1:0] m2_out;
    logic [W_OUT-1:0] m4_out;
    logic [W_OUT-1:0] m8_out;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output start, x_in, out_ready,
        input  busy, m1_out, m2_out, m4_out, m8_out, out_valid
    );

    modport slave (
        input  start, x_in, out_ready,
        output busy, m1_out, m2_out, m4_out, m8_out, out_valid
    );

endinterface

// File: rtl/dec_double_4221.sv
// Combinational decimal doubler for 4221-coded operands: each digit is
// recoded to 5211 and shifted left one bit, the MSB rippling into the next digit.
module dec_double_4221
    import dec_mult_pkg::*;
#(
    parameter int NUM_DIG = 17
) (
    input  logic [DIG_W*NUM_DIG-1:0] dig_in,
    output logic [DIG_W*NUM_DIG-1:0] dig_out
);

    // carry_s[i] is the bit shifted into digit i; nothing enters digit 0.
    logic [NUM_DIG-1:0] carry_s;

    assign carry_s[0] = 1'b0;

    genvar i;
    for (i = 0; i < NUM_DIG; i++) begin : g_dig
        assign dig_out[DIG_W*i +: DIG_W] = dbl_digit(dig_in[DIG_W*i +: DIG_W], carry_s[i]);
        // The carry out of the top digit is always 0 for operands this wide.
        if (i < NUM_DIG - 1) begin : g_carry
            assign carry_s[i+1] = dbl_carry(dig_in[DIG_W*i +: DIG_W]);
        end
    end

endmodule

// File: rtl/dec_multiple_gen_ctrl.sv
// Sequencer producing X, 2X, 4X and 8X (4221 coded) with one doubling per
// cycle; results are held until the partial-product stage accepts them.
module dec_multiple_gen_ctrl
    import dec_mult_pkg::*;
#(
    parameter int N_DIG = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    dec_multiple_gen_ctrl_if.slave bus
);

    localparam int W_OUT = DIG_W * (N_DIG + 1);

    state_e           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [W_OUT-1:0] work_q, work_d;
    logic [W_OUT-1:0] m1_q, m1_d;
    logic [W_OUT-1:0] m2_q, m2_d;
    logic [W_OUT-1:0] m4_q, m4_d;
    logic [W_OUT-1:0] m8_q, m8_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic [W_OUT-1:0] dbl_s;

    dec_double_4221 #(.NUM_DIG(N_DIG + 1)) u_double (
        .dig_in  (work_q),
        .dig_out (dbl_s)
    );

    // Next-state, working register, step counter and result capture.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        work_d  = work_q;
        m1_d    = m1_q;
        m2_d    = m2_q;
        m4_d    = m4_q;
        m8_d    = m8_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    work_d  = {{DIG_W{1'b0}}, bus.x_in};
                    m1_d    = {{DIG_W{1'b0}}, bus.x_in};
                    step_d  = 2'd0;
                    state_d = ST_DBL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DBL: begin
                work_d = dbl_s;
                step_d = step_q + 2'd1;
                case (step_q)
                    2'd0:    m2_d = dbl_s;
                    2'd1:    m4_d = dbl_s;
                    2'd2:    m8_d = dbl_s;
                    default: m8_d = m8_q;
                endcase
                if (step_q >= 2'd2) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_DBL;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_HOLD);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= 2'd0;
            work_q      <= {W_OUT{1'b0}};
            m1_q        <= {W_OUT{1'b0}};
            m2_q        <= {W_OUT{1'b0}};
            m4_q        <= {W_OUT{1'b0}};
            m8_q        <= {W_OUT{1'b0}};
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            work_q      <= work_d;
            m1_q        <= m1_d;
            m2_q        <= m2_d;
            m4_q        <= m4_d;
            m8_q        <= m8_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.m1_out    = m1_q;
    assign bus.m2_out    = m2_q;
    assign bus.m4_out    = m4_q;
    assign bus.m8_out    = m8_q;

endmodule

// File: tb/tb_dec_multiple_gen_ctrl.sv
// Randomized self-checking bench for dec_multiple_gen_ctrl; expected
// multiples come from integer arithmetic on the decoded operand.
module tb_dec_multiple_gen_ctrl;

    localparam int N     = 4;
    localparam int W_IN  = 4 * N;
    localparam int W_OUT = 4 * (N + 1);

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    dec_multiple_gen_ctrl_if #(.N_DIG(N)) bus ();

    dec_multiple_gen_ctrl #(.N_DIG(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Decimal value of a 4221-coded number, weights 4,2,2,1 per digit.
    function automatic longint dec_val(input logic [W_OUT-1:0] v);
        longint acc = 0;
        longint p   = 1;
        for (int i = 0; i < N + 1; i++) begin
            acc += p * (4 * int'(v[4*i+3]) + 2 * int'(v[4*i+2])
                      + 2 * int'(v[4*i+1]) + int'(v[4*i]));
            p *= 10;
        end
        return acc;
    endfunction

    function automatic longint op_val(input logic [W_IN-1:0] x);
        return dec_val({4'b0000, x});
    endfunction

    task automatic do_start(input logic [W_IN-1:0] x);
        @(negedge clk);
        bus.x_in  = x;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.out_valid && k < 20);
        check_eq({tag, " latency"}, k, 3);
    endtask

    task automatic check_mults(input string tag, input logic [W_IN-1:0] x);
        longint v = op_val(x);
        check_eq({tag, " m1 bits"}, longint'(bus.m1_out), longint'({4'b0000, x}));
        check_eq({tag, " m2"}, dec_val(bus.m2_out), 2 * v);
        check_eq({tag, " m4"}, dec_val(bus.m4_out), 4 * v);
        check_eq({tag, " m8"}, dec_val(bus.m8_out), 8 * v);
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq({tag, " valid after accept"}, longint'(bus.out_valid), 0);
        check_eq({tag, " busy after accept"}, longint'(bus.busy), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, " busy"}, longint'(bus.busy), 0);
        check_eq({tag, " out_valid"}, longint'(bus.out_valid), 0);
        check_eq({tag, " m1"}, longint'(bus.m1_out), 0);
        check_eq({tag, " m2"}, longint'(bus.m2_out), 0);
        check_eq({tag, " m4"}, longint'(bus.m4_out), 0);
        check_eq({tag, " m8"}, longint'(bus.m8_out), 0);
    endtask

    initial begin
        logic [W_IN-1:0]  x;
        logic [W_IN-1:0]  x_new;
        logic [W_OUT-1:0] hold_m1;
        logic [W_OUT-1:0] hold_m8;
        logic [3:0]       top_dig;
        longint           red_m2, red_m4, red_m8;
        int               rises[$];
        logic             prev_busy;

        n_cmp = 0;
        n_err = 0;
        bus.start     = 1'b0;
        bus.x_in      = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        // Basic 1234
        x = {4'b0001, 4'b0100, 4'b0101, 4'b1000};
        do_start(x);
        check_eq("basic busy", longint'(bus.busy), 1);
        wait_valid("basic");
        check_mults("basic", x);
        check_eq("basic m1 value", dec_val(bus.m1_out), 1234);
        check_eq("basic m2 value", dec_val(bus.m2_out), 2468);
        check_eq("basic m4 value", dec_val(bus.m4_out), 4936);
        check_eq("basic m8 value", dec_val(bus.m8_out), 9872);
        accept("basic");

        // Max operand 9999
        x = {W_IN{1'b1}};
        do_start(x);
        wait_valid("max");
        check_mults("max", x);
        check_eq("max m8 value", dec_val(bus.m8_out), 79992);
        top_dig = bus.m2_out[W_OUT-1 -: 4];
        check_eq("max m2 top digit", dec_val({16'h0000, top_dig}), 1);
        accept("max");

        // Redundant codings of 5656
        x = {4'b1001, 4'b1100, 4'b1001, 4'b1100};
        do_start(x);
        wait_valid("redA");
        check_mults("redA", x);
        red_m2 = dec_val(bus.m2_out);
        red_m4 = dec_val(bus.m4_out);
        red_m8 = dec_val(bus.m8_out);
        accept("redA");
        x = {4'b0111, 4'b1010, 4'b0111, 4'b1010};
        do_start(x);
        wait_valid("redB");
        check_mults("redB", x);
        check_eq("redundant m2 equal", dec_val(bus.m2_out), red_m2);
        check_eq("redundant m4 equal", dec_val(bus.m4_out), red_m4);
        check_eq("redundant m8 equal", dec_val(bus.m8_out), red_m8);
        accept("redB");

        // Backpressure with starts during DBL and HOLD
        x     = {4'b0011, 4'b0110, 4'b1011, 4'b0001};
        x_new = {4'b1000, 4'b0001, 4'b0000, 4'b1110};
        @(negedge clk);
        bus.x_in  = x;
        bus.start = 1'b1;
        @(negedge clk);
        bus.x_in = x_new;
        wait_valid("bp");
        check_mults("bp", x);
        hold_m1 = bus.m1_out;
        hold_m8 = bus.m8_out;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("bp hold valid", longint'(bus.out_valid), 1);
            check_eq("bp hold busy", longint'(bus.busy), 1);
            check_eq("bp hold m1", longint'(bus.m1_out), longint'(hold_m1));
            check_eq("bp hold m8", longint'(bus.m8_out), longint'(hold_m8));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("bp accept busy", longint'(bus.busy), 0);
        check_eq("bp accept m1", longint'(bus.m1_out), longint'(hold_m1));
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("bp reload busy", longint'(bus.busy), 1);
        check_eq("bp reload m1", longint'(bus.m1_out), longint'({4'b0000, x_new}));
        wait_valid("bp new");
        check_mults("bp new", x_new);
        accept("bp new");

        // Reset at edge t+2 of an operation
        do_start({4'b0111, 4'b0111, 4'b0111, 4'b0111});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("midrst");
        x = {4'b0000, 4'b0000, 4'b1000, 4'b0100};
        do_start(x);
        wait_valid("after rst");
        check_mults("after rst", x);
        check_eq("after rst m8 value", dec_val(bus.m8_out), 336);
        accept("after rst");

        // Random operands with random hold time
        for (int r = 0; r < 8; r++) begin
            x = W_IN'($urandom());
            do_start(x);
            wait_valid("rand");
            check_mults("rand", x);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check_eq("rand hold valid", longint'(bus.out_valid), 1);
            end
            accept("rand");
        end

        // Zero operand
        x = '0;
        do_start(x);
        wait_valid("zero");
        check_mults("zero", x);
        accept("zero");

        // Back-to-back: start held, out_ready held
        x = {4'b0000, 4'b1010, 4'b0001, 4'b1111};
        @(negedge clk);
        bus.x_in      = x;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        prev_busy     = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.busy && !prev_busy) rises.push_back(c);
            prev_busy = bus.busy;
        end
        bus.start = 1'b0;
        check_eq("b2b op count", longint'(rises.size() >= 3), 1);
        for (int j = 1; j < rises.size(); j++) begin
            check_eq("b2b interval", longint'(rises[j] - rises[j-1]), 5);
        end
        repeat (6) @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("b2b idle", longint'(bus.busy), 0);
        check_mults("b2b", x);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
